rtc_timer: RTL
==============

# rtc_timer

Programmable interval timer driven by the one-clock-wide tick from the clock divider. It counts divider ticks against a software-loaded preset and raises a flag every N ticks, in one-shot or repeating mode. The flag is gated with an interrupt enable to request a CPU interrupt. It sits between the fixed-rate tick source and the IOT decode logic, which drives its command strobes and reads its status.

## Interface

**Parameters**
- `WIDTH`, default 12: width of the preset and counter (one PDP-8 word).

**Ports**
- `clock`, in, 1: master clock, the same clock that feeds the divider.
- `reset`, in, 1: synchronous, active-high reset.
- `tick`, in, 1: one-clock pulse from the clock divider at the timebase rate.
- `data_in`, in, WIDTH: preset value, sampled on `load`.
- `load`, in, 1: strobe; write `data_in` to the preset register.
- `start`, in, 1: strobe; copy the preset to the counter and enter RUN.
- `stop`, in, 1: strobe; enter IDLE, counter holds its value.
- `repeat_in`, in, 1: mode sampled on `start`; 1 = repeating, 0 = one-shot.
- `clr_flag`, in, 1: strobe; clear `flag` and `overrun`.
- `ie_wr`, in, 1: strobe; write `ie_in` to the interrupt-enable bit.
- `ie_in`, in, 1: interrupt-enable value.
- `count`, out, WIDTH: current counter value.
- `running`, out, 1: 1 while in the RUN state.
- `flag`, out, 1: sticky terminal-count flag.
- `irq`, out, 1: `flag & ie`, combinational from registers.
- `overrun`, out, 1: sticky; a terminal count occurred while `flag` was already set.

## Operation

- **Registers:** `preset`, `count`, `mode`, `ie`, `flag`, `overrun`, and the state bit (IDLE/RUN).
- **Reset:** every register, and therefore every output, is 0. State is IDLE.
- **`load`:** `preset <= data_in`. If the block is IDLE and `start` is not asserted, also `count <= data_in`.
- **`start`:**
  - `count <= preset`, or `data_in` if `load` is asserted in the same cycle.
  - `mode <= repeat_in`; state goes to RUN.
  - `start` while already in RUN restarts the count.
- **`stop`:** state goes to IDLE and `count` holds. `stop` wins over `start` in the same cycle.
- **`tick` in RUN (and no `start` or `stop` this cycle):**
  - If `count == 1`, this is a **terminal count**:
    - `flag <= 1`.
    - Repeating mode: `count <= preset`.
    - One-shot mode: `count <= 0` and state goes to IDLE.
  - Otherwise `count <= count - 1`, wrapping modulo 2^WIDTH.
- **Preset 0** gives a period of 2^WIDTH ticks: the counter wraps 0 -> all-ones and terminates at 1.
- **Preset 1** terminates on every tick.
- **`tick` in IDLE:** ignored.
- **`tick` in the same cycle as `start`:** ignored; the first counted tick is the next one.
- **Terminal count while `flag` is already 1:** `overrun <= 1` (when the overrun feature is compiled in; see Configuration).
- **`clr_flag` in the same cycle as a terminal count:** the clear is applied first. Result is `flag = 1`, `overrun = 0`.
- **`ie_wr`:** `ie <= ie_in`. `irq` follows in the same cycle as `ie` and `flag` change.

## Timing

- All state updates occur on the rising edge of `clock`. Strobes are sampled every cycle and are level-qualified, one cycle each.
- Terminal tick in cycle T: `flag` and `irq` are high from T+1, and `count` shows the reloaded value at T+1.
- The flag period in repeating mode is exactly `preset` ticks (2^WIDTH for preset 0), with no slip across reloads.
- `start` in cycle S: `running` is high and `count == preset` at S+1.
- Reset asserted mid-run: at the next edge all outputs are 0. Any pending strobes in that cycle are ignored.
- No combinational path from inputs to outputs. `irq` depends only on registers.

## Configuration

- **`RTC_OVERRUN_EN` defined:** the overrun register and logic are built. `overrun` behaves as described in Operation.
- **`RTC_OVERRUN_EN` undefined:** no overrun register is built and `overrun` is tied to 0. All other behaviour is identical.

## Test plan

- **Reset and basic repeat:** assert reset, then load 3 and start with `repeat_in = 1`, sending 9 ticks. Required: `flag` first set after tick 3; `count` sequence 3, 2, 1, 3, 2, 1, ... ; flag asserted 3 times if cleared between.
- **One-shot:** load 2, start with `repeat_in = 0`, send 4 ticks. Required: `flag = 1` after tick 2; `running = 0` and `count = 0` thereafter; ticks 3-4 have no effect.
- **Preset 0 wrap:** with `WIDTH = 4`, load 0, start repeating. Required: `count` goes 0, 15, 14, ..., 1, and the first terminal count occurs on tick 16.
- **Overrun and simultaneity (with `RTC_OVERRUN_EN`):**
  - Preset 1, leave `flag` set, send a second tick. Required: `overrun = 1`.
  - Then `clr_flag` in the same cycle as a tick. Required: `flag = 1`, `overrun = 0`.
  - Without the macro, `overrun` stays 0 throughout.
- **Interrupt gating:** `flag` set with `ie = 0` gives `irq = 0`. `ie_wr` with `ie_in = 1` gives `irq = 1` on the next cycle. `clr_flag` gives `irq = 0` on the next cycle.
- **Command collisions:**
  - `start` and `stop` together: block stays IDLE.
  - `load` 5 and `start` together: `count = 5`.
  - `tick` coinciding with `start`: not counted.
  - Reset mid-run with preset 7 at count 4: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/rtc_timer_if.sv
// rtc_timer_if: command strobes, tick and status lines between IOT decode and the interval timer
interface rtc_timer_if #(parameter int WIDTH = 12);
    logic             tick;
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             start;
    logic             stop;
    logic             repeat_in;
    logic             clr_flag;
    logic             ie_wr;
    logic             ie_in;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             flag;
    logic             irq;
    logic             overrun;
    modport master (
        output tick, data_in, load, start, stop, repeat_in, clr_flag, ie_wr, ie_in,
        input  count, running, flag, irq, overrun
    );
    modport slave (
        input  tick, data_in, load, start, stop, repeat_in, clr_flag, ie_wr, ie_in,
        output count, running, flag, irq, overrun
    );
endinterface

// File: rtl/rtc_timer.sv
// rtc_timer: programmable tick-interval timer with sticky flag, interrupt gating and one-shot/repeat modes
// Define RTC_OVERRUN_EN to build the overrun register; otherwise overrun is tied to 0.
module rtc_timer #(parameter int WIDTH = 12) (
    input logic       clock,
    input logic       reset,
    rtc_timer_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] preset, count, count_n;
    logic             mode, ie, flag;
    logic             term, idle_load;
    assign term      = state == RUN && bus.tick && !bus.start && !bus.stop && count == WIDTH'(1);
    assign idle_load = bus.load && state == IDLE && !bus.start;
    // Next state and next count: stop beats start, start beats counting, ticks only count in RUN
    always_comb begin
        state_n = state;
        count_n = count;
        if (bus.stop)
            state_n = IDLE;
        else if (bus.start)
            state_n = RUN;
        else if (term && !mode)
            state_n = IDLE;
        if (idle_load)
            count_n = bus.data_in;
        else if (bus.stop)
            count_n = count;
        else if (bus.start)
            count_n = bus.load ? bus.data_in : preset;
        else if (state == RUN && bus.tick)
            count_n = term ? (mode ? preset : '0) : count - WIDTH'(1);
    end
    // State register
    always_ff @(posedge clock)
        state <= reset ? IDLE : state_n;
    // Preset, counter, mode, interrupt enable and the sticky flag (clear applied before a new terminal count)
    always_ff @(posedge clock) begin
        if (reset) begin
            preset <= '0;
            count  <= '0;
            mode   <= 1'b0;
            ie     <= 1'b0;
            flag   <= 1'b0;
        end else begin
            if (bus.load)
                preset <= bus.data_in;
            if (bus.start && !bus.stop)
                mode <= bus.repeat_in;
            if (bus.ie_wr)
                ie <= bus.ie_in;
            count <= count_n;
            flag  <= term | (flag & ~bus.clr_flag);
        end
    end
`ifdef RTC_OVERRUN_EN
    logic overrun;
    // Overrun: a terminal count that finds the flag still set after any same-cycle clear
    always_ff @(posedge clock)
        overrun <= reset ? 1'b0 : ~bus.clr_flag & (overrun | (term & flag));
    assign bus.overrun = overrun;
`else
    assign bus.overrun = 1'b0;
`endif
    assign bus.count   = count;
    assign bus.running = state == RUN;
    assign bus.flag    = flag;
    assign bus.irq     = flag & ie;
endmodule
